// File: rtl/vga_scan_pkg.sv
// Shared types and constants for the VGA pixel scanner: FSM states, widths, and the checksum step.
package vga_scan_pkg;

  typedef enum logic [1:0] {IDLE, PRESENT, WAIT, ADVANCE} scan_state_e;

  localparam int COLOR_W = 24;
  localparam int MISS_W  = 20;

  // Rotate left by one, then fold in the pixel colour.
  function automatic logic [COLOR_W-1:0] csum_step(input logic [COLOR_W-1:0] sum,
                                                   input logic [COLOR_W-1:0] color);
    return {sum[COLOR_W-2:0], sum[COLOR_W-1]} ^ color;
  endfunction

endpackage

// File: rtl/vga_pixel_scanner_if.sv
// Signal bundle between the pixel scanner and the painter/sink.
// The scanner modport drives the coordinates and the stream; the host modport drives the rest.
interface vga_pixel_scanner_if #(
  parameter int XW = 10,
  parameter int YW = 9
);
  import vga_scan_pkg::*;

  logic               start;
  logic [XW-1:0]      VGA_X;
  logic [YW-1:0]      VGA_Y;
  logic [COLOR_W-1:0] VGA_COLOR;
  logic               plot;
  logic               pix_valid;
  logic [XW-1:0]      pix_x;
  logic [YW-1:0]      pix_y;
  logic [COLOR_W-1:0] pix_color;
  logic               pix_miss;
  logic               busy;
  logic               frame_done;
  logic [MISS_W-1:0]  miss_count;
  logic [COLOR_W-1:0] frame_sum;

  modport scanner (
    input  start, VGA_COLOR, plot,
    output VGA_X, VGA_Y, pix_valid, pix_x, pix_y, pix_color, pix_miss,
           busy, frame_done, miss_count, frame_sum
  );

  modport host (
    output start, VGA_COLOR, plot,
    input  VGA_X, VGA_Y, pix_valid, pix_x, pix_y, pix_color, pix_miss,
           busy, frame_done, miss_count, frame_sum
  );
endinterface

// File: rtl/vga_raster_counter.sv
// Raster x/y walker: clear to (0,0), park at (H_RES-1,V_RES-1), step with line wrap.
module vga_raster_counter #(
  parameter int H_RES = 640,
  parameter int V_RES = 480,
  parameter int XW    = 10,
  parameter int YW    = 9
)(
  input  logic          gclk,
  input  logic          grst_n,
  input  logic          enable,
  input  logic          clear,
  input  logic          park,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic          last
);
  localparam logic [XW-1:0] X_MAX = XW'(H_RES - 1);
  localparam logic [YW-1:0] Y_MAX = YW'(V_RES - 1);

  logic [XW-1:0] r_x;
  logic [YW-1:0] r_y;

  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      r_x <= X_MAX;
      r_y <= Y_MAX;
    end else if (clear) begin
      r_x <= '0;
      r_y <= '0;
    end else if (park) begin
      r_x <= X_MAX;
      r_y <= Y_MAX;
    end else if (enable) begin
      if (r_x == X_MAX) begin
        r_x <= '0;
        r_y <= (r_y == Y_MAX) ? '0 : r_y + 1'b1;
      end else begin
        r_x <= r_x + 1'b1;
      end
    end
  end

  assign x    = r_x;
  assign y    = r_y;
  assign last = (r_x == X_MAX) && (r_y == Y_MAX);

endmodule

// File: rtl/vga_pixel_scanner.sv
// Drives a raster of coordinates to a painter, captures each plot, emits a pixel stream with misses.
// Optional frame checksum enabled by defining VGA_SCANNER_CHECKSUM_EN.
module vga_pixel_scanner
  import vga_scan_pkg::*;
#(
  parameter int H_RES   = 640,
  parameter int V_RES   = 480,
  parameter int XW      = 10,
  parameter int YW      = 9,
  parameter int TIMEOUT = 15
)(
  input  logic               CLOCK_50,
  input  logic               resetn,
  input  logic               start,
  output logic [XW-1:0]      VGA_X,
  output logic [YW-1:0]      VGA_Y,
  input  logic [COLOR_W-1:0] VGA_COLOR,
  input  logic               plot,
  output logic               pix_valid,
  output logic [XW-1:0]      pix_x,
  output logic [YW-1:0]      pix_y,
  output logic [COLOR_W-1:0] pix_color,
  output logic               pix_miss,
  output logic               busy,
  output logic               frame_done,
  output logic [MISS_W-1:0]  miss_count,
  output logic [COLOR_W-1:0] frame_sum
);
  localparam int TW = $clog2(TIMEOUT + 1);

  scan_state_e        r_state, w_next;
  logic [TW-1:0]      r_wcnt;
  logic               w_last, w_accept, w_hit, w_tmo;
  logic               w_cnt_en, w_cnt_clr, w_cnt_park;
  logic               r_pix_valid, r_pix_miss, r_busy, r_frame_done;
  logic [XW-1:0]      r_pix_x;
  logic [YW-1:0]      r_pix_y;
  logic [COLOR_W-1:0] r_pix_color;
  logic [MISS_W-1:0]  r_miss;

  // start coinciding with frame_done is dropped; it must be seen again in a plain IDLE cycle.
  assign w_accept = (r_state == IDLE) && start && !r_frame_done;
  assign w_hit    = (r_state == WAIT) && plot;
  // Last in-window cycle without a plot: the counter would reach TIMEOUT on the next edge.
  assign w_tmo    = (r_state == WAIT) && !plot && (r_wcnt == TW'(TIMEOUT - 1));

  always_comb begin
    w_next     = r_state;
    w_cnt_en   = 1'b0;
    w_cnt_clr  = 1'b0;
    w_cnt_park = 1'b0;
    case (r_state)
      IDLE:    if (w_accept) begin w_next = PRESENT; w_cnt_clr = 1'b1; end
      PRESENT: w_next = WAIT;
      WAIT:    if (w_hit || w_tmo) w_next = ADVANCE;
      ADVANCE: begin
        if (w_last) begin w_next = IDLE; w_cnt_park = 1'b1; end
        else begin w_next = PRESENT; w_cnt_en = 1'b1; end
      end
      default: w_next = IDLE;
    endcase
  end

  vga_raster_counter #(.H_RES(H_RES), .V_RES(V_RES), .XW(XW), .YW(YW)) u_raster (
    .gclk(CLOCK_50), .grst_n(resetn), .enable(w_cnt_en), .clear(w_cnt_clr),
    .park(w_cnt_park), .x(VGA_X), .y(VGA_Y), .last(w_last)
  );

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      r_state      <= IDLE;
      r_wcnt       <= '0;
      r_pix_valid  <= 1'b0;
      r_pix_miss   <= 1'b0;
      r_pix_x      <= '0;
      r_pix_y      <= '0;
      r_pix_color  <= '0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
      r_miss       <= '0;
    end else begin
      r_state      <= w_next;
      r_wcnt       <= (r_state == WAIT) ? r_wcnt + 1'b1 : '0;
      r_pix_valid  <= w_hit || w_tmo;
      r_frame_done <= (r_state == ADVANCE) && w_last;
      if (w_hit || w_tmo) begin
        r_pix_x     <= VGA_X;
        r_pix_y     <= VGA_Y;
        r_pix_miss  <= w_tmo;
        r_pix_color <= w_hit ? VGA_COLOR : '0;
      end
      if (w_accept)                               r_busy <= 1'b1;
      else if ((r_state == ADVANCE) && w_last)    r_busy <= 1'b0;
      if (w_accept)                               r_miss <= '0;
      else if (w_tmo && !(&r_miss))               r_miss <= r_miss + 1'b1;
    end
  end

`ifdef VGA_SCANNER_CHECKSUM_EN
  logic [COLOR_W-1:0] r_sum;
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn)          r_sum <= '0;
    else if (w_accept)    r_sum <= '0;
    else if (r_pix_valid) r_sum <= csum_step(r_sum, r_pix_color);
  end
  assign frame_sum = r_sum;
`else
  assign frame_sum = '0;
`endif

  assign pix_valid  = r_pix_valid;
  assign pix_x      = r_pix_x;
  assign pix_y      = r_pix_y;
  assign pix_color  = r_pix_color;
  assign pix_miss   = r_pix_miss;
  assign busy       = r_busy;
  assign frame_done = r_frame_done;
  assign miss_count = r_miss;

endmodule

// File: tb/tb_vga_pixel_scanner.sv
// Directed bench: 4x3 raster with a configurable painter, plus a 2x1 raster for the checksum.
module tb_vga_pixel_scanner;
  import vga_scan_pkg::*;

  localparam int T = 5;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  vga_pixel_scanner_if #(.XW(10), .YW(9)) a();
  vga_pixel_scanner_if #(.XW(10), .YW(9)) b();

  vga_pixel_scanner #(.H_RES(4), .V_RES(3), .XW(10), .YW(9), .TIMEOUT(T)) u_a (
    .CLOCK_50(clk), .resetn(rst_n), .start(a.start), .VGA_X(a.VGA_X), .VGA_Y(a.VGA_Y),
    .VGA_COLOR(a.VGA_COLOR), .plot(a.plot), .pix_valid(a.pix_valid), .pix_x(a.pix_x),
    .pix_y(a.pix_y), .pix_color(a.pix_color), .pix_miss(a.pix_miss), .busy(a.busy),
    .frame_done(a.frame_done), .miss_count(a.miss_count), .frame_sum(a.frame_sum)
  );

  vga_pixel_scanner #(.H_RES(2), .V_RES(1), .XW(10), .YW(9), .TIMEOUT(T)) u_b (
    .CLOCK_50(clk), .resetn(rst_n), .start(b.start), .VGA_X(b.VGA_X), .VGA_Y(b.VGA_Y),
    .VGA_COLOR(b.VGA_COLOR), .plot(b.plot), .pix_valid(b.pix_valid), .pix_x(b.pix_x),
    .pix_y(b.pix_y), .pix_color(b.pix_color), .pix_miss(b.pix_miss), .busy(b.busy),
    .frame_done(b.frame_done), .miss_count(b.miss_count), .frame_sum(b.frame_sum)
  );

  // Painter A: plots d cycles after a coordinate change (d=1 nominal, d=0 silent).
  int sp_x[2], sp_y[2], sp_d[2];
  logic [18:0] prev_a;
  int dcnt_a = 0;

  function automatic int pdly(input logic [9:0] x, input logic [8:0] y);
    for (int i = 0; i < 2; i++)
      if (sp_x[i] == int'(x) && sp_y[i] == int'(y)) return sp_d[i];
    return 1;
  endfunction

  always @(posedge clk) begin
    prev_a <= {a.VGA_X, a.VGA_Y};
    a.plot <= 1'b0;
    if ({a.VGA_X, a.VGA_Y} !== prev_a) begin
      if (pdly(a.VGA_X, a.VGA_Y) == 1) a.plot <= 1'b1;
      dcnt_a <= (pdly(a.VGA_X, a.VGA_Y) > 1) ? pdly(a.VGA_X, a.VGA_Y) - 1 : 0;
    end else if (dcnt_a != 0) begin
      dcnt_a <= dcnt_a - 1;
      if (dcnt_a == 1) a.plot <= 1'b1;
    end
  end
  assign a.VGA_COLOR = {5'd0, a.VGA_X, a.VGA_Y};

  logic [18:0] prev_b;
  always @(posedge clk) begin
    prev_b <= {b.VGA_X, b.VGA_Y};
    b.plot <= ({b.VGA_X, b.VGA_Y} !== prev_b);
  end
  assign b.VGA_COLOR = (b.VGA_X == 10'd0) ? 24'h000001 : 24'h000002;

  int fd_a = 0, pv_a = 0;
  always @(negedge clk) begin
    if (a.frame_done === 1'b1) fd_a <= fd_a + 1;
    if (a.pix_valid === 1'b1)  pv_a <= pv_a + 1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_pix(output int n);
    n = 0;
    do begin @(negedge clk); n++; end while (a.pix_valid !== 1'b1 && n < 100);
    chk("pix_wait_bound", 32'(n < 100), 32'd1);
  endtask

  task automatic wait_done(output int n);
    n = 0;
    do begin @(negedge clk); n++; end while (a.frame_done !== 1'b1 && n < 200);
    chk("done_wait_bound", 32'(n < 200), 32'd1);
  endtask

  task automatic exp_pix(input string tag, input int x, input int y, input logic miss);
    chk({tag, "_x"}, 32'(a.pix_x), 32'(x));
    chk({tag, "_y"}, 32'(a.pix_y), 32'(y));
    chk({tag, "_miss"}, 32'(a.pix_miss), 32'(miss));
    chk({tag, "_color"}, 32'(a.pix_color), miss ? 32'd0 : 32'((x << 9) | y));
  endtask

  task automatic clear_sp();
    for (int i = 0; i < 2; i++) begin sp_x[i] = -1; sp_y[i] = -1; sp_d[i] = 1; end
  endtask

  task automatic start_a();
    @(negedge clk) a.start = 1'b1;
    @(negedge clk) a.start = 1'b0;
  endtask

  initial begin
    int n, fd0, pv0;
    logic [31:0] exp_sum1;
    a.start = 1'b0; b.start = 1'b0; rst_n = 1'b0;
    clear_sp();
    repeat (2) @(negedge clk);
    chk("rst_vga_x", 32'(a.VGA_X), 32'd3);
    chk("rst_vga_y", 32'(a.VGA_Y), 32'd2);
    chk("rst_busy", 32'(a.busy), 32'd0);
    chk("rst_pix_valid", 32'(a.pix_valid), 32'd0);
    chk("rst_frame_done", 32'(a.frame_done), 32'd0);
    chk("rst_miss_count", 32'(a.miss_count), 32'd0);
    chk("rst_frame_sum", 32'(a.frame_sum), 32'd0);
    chk("rst_pix_color", 32'(a.pix_color), 32'd0);
    chk("rst_b_vga_x", 32'(b.VGA_X), 32'd1);
    @(negedge clk) rst_n = 1'b1;

    // Frame 1: every pixel hit, raster order
    start_a();
    chk("f1_busy", 32'(a.busy), 32'd1);
    chk("f1_first_xy", 32'({a.VGA_X, a.VGA_Y}), 32'd0);
    for (int i = 0; i < 12; i++) begin
      wait_pix(n);
      exp_pix("f1", i % 4, i / 4, 1'b0);
    end
    wait_done(n);
    chk("f1_done_latency", 32'(n), 32'd1);
    chk("f1_busy_at_done", 32'(a.busy), 32'd0);
    chk("f1_park_x", 32'(a.VGA_X), 32'd3);
    chk("f1_park_y", 32'(a.VGA_Y), 32'd2);
    chk("f1_miss_count", 32'(a.miss_count), 32'd0);
    #1;
    chk("f1_pv_count", 32'(pv_a), 32'd12);
    chk("f1_fd_count", 32'(fd_a), 32'd1);

    // Frame 2: painter silent at (2,1)
    sp_x[0] = 2; sp_y[0] = 1; sp_d[0] = 0;
    start_a();
    for (int i = 0; i < 12; i++) begin
      wait_pix(n);
      exp_pix("f2", i % 4, i / 4, i == 6);
      chk("f2_gap", 32'(n), (i == 0) ? 32'd2 : (i == 6) ? 32'(T + 2) : 32'd3);
      if (i == 6) chk("f2_miss_now", 32'(a.miss_count), 32'd1);
    end
    wait_done(n);
    chk("f2_miss_count", 32'(a.miss_count), 32'd1);

    // Frame 3: plot at last in-window cycle (hit) vs one cycle later (miss)
    sp_x[0] = 1; sp_y[0] = 0; sp_d[0] = T;
    sp_x[1] = 2; sp_y[1] = 0; sp_d[1] = T + 1;
    start_a();
    for (int i = 0; i < 12; i++) begin
      wait_pix(n);
      exp_pix("f3", i % 4, i / 4, i == 2);
      chk("f3_gap", 32'(n), (i == 0) ? 32'd2 : (i == 1 || i == 2) ? 32'(T + 2) : 32'd3);
      if (i == 2) chk("f3_late_plot_present", 32'(a.plot), 32'd1);
    end
    wait_done(n);
    chk("f3_miss_count", 32'(a.miss_count), 32'd1);

    // Frame 4: reset while pixel (1,1) is presented
    clear_sp();
    sp_x[0] = 0; sp_y[0] = 0; sp_d[0] = 0;
    start_a();
    for (int i = 0; i < 5; i++) wait_pix(n);
    @(negedge clk);
    chk("f4_at_1_1", 32'({a.VGA_X, a.VGA_Y}), 32'({10'd1, 9'd1}));
    fd0 = fd_a;
    #2 rst_n = 1'b0;
    #1;
    chk("f4_rst_vga", 32'({a.VGA_X, a.VGA_Y}), 32'({10'd3, 9'd2}));
    chk("f4_rst_busy", 32'(a.busy), 32'd0);
    chk("f4_rst_miss", 32'(a.miss_count), 32'd0);
    chk("f4_rst_pix_y", 32'(a.pix_y), 32'd0);
    chk("f4_rst_color", 32'(a.pix_color), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("f4_no_done", 32'(fd_a), 32'(fd0));
    chk("f4_idle_busy", 32'(a.busy), 32'd0);
    clear_sp();
    start_a();
    wait_pix(n);
    exp_pix("f4_restart", 0, 0, 1'b0);
    for (int i = 1; i < 12; i++) wait_pix(n);
    wait_done(n);

    // Back-to-back frames with start held high
    @(negedge clk) a.start = 1'b1;
    #1 pv0 = pv_a;
    for (int i = 0; i < 12; i++) begin
      wait_pix(n);
      if (i == 1) exp_pix("b2b_p1", 1, 0, 1'b0);
    end
    wait_done(n);
    chk("b2b_busy_done", 32'(a.busy), 32'd0);
    #1 chk("b2b_pv_count", 32'(pv_a - pv0), 32'd12);
    @(negedge clk);
    chk("b2b_ignored_busy", 32'(a.busy), 32'd0);
    chk("b2b_ignored_vga", 32'({a.VGA_X, a.VGA_Y}), 32'({10'd3, 9'd2}));
    @(negedge clk);
    chk("b2b_restart_busy", 32'(a.busy), 32'd1);
    chk("b2b_restart_vga", 32'({a.VGA_X, a.VGA_Y}), 32'd0);
    a.start = 1'b0;
    for (int i = 0; i < 12; i++) wait_pix(n);
    wait_done(n);

    // 2x1 frame: checksum 0 -> 1 -> 0
`ifdef VGA_SCANNER_CHECKSUM_EN
    exp_sum1 = 32'd1;
`else
    exp_sum1 = 32'd0;
`endif
    @(negedge clk) b.start = 1'b1;
    @(negedge clk) b.start = 1'b0;
    chk("b_sum_start", 32'(b.frame_sum), 32'd0);
    n = 0;
    do begin @(negedge clk); n++; end while (b.pix_valid !== 1'b1 && n < 100);
    chk("b_pix0_bound", 32'(n < 100), 32'd1);
    chk("b_pix0_color", 32'(b.pix_color), 32'h1);
    @(negedge clk);
    chk("b_sum_pix0", 32'(b.frame_sum), exp_sum1);
    n = 0;
    do begin @(negedge clk); n++; end while (b.pix_valid !== 1'b1 && n < 100);
    chk("b_pix1_bound", 32'(n < 100), 32'd1);
    chk("b_pix1_color", 32'(b.pix_color), 32'h2);
    chk("b_pix1_x", 32'(b.pix_x), 32'd1);
    @(negedge clk);
    chk("b_frame_done", 32'(b.frame_done), 32'd1);
    chk("b_sum_end", 32'(b.frame_sum), 32'd0);
    chk("b_park", 32'({b.VGA_X, b.VGA_Y}), 32'({10'd1, 9'd0}));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
